// File: rtl/vending_core.sv
// vending_core: coin credit, item selection, dispense and change handshake controller (optional VEND_TIMEOUT_EN auto-refund)
module vending_core #(
  parameter int NUM_ITEMS   = 4,
  parameter int CREDIT_W    = 8,
  parameter int MAX_CREDIT  = 200,
  parameter int STOCK_W     = 4,
  parameter int STOCK_INIT  = 5,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin_valid,
  input  logic [CREDIT_W-1:0]           coin_value,
  input  logic                          sel_valid,
  input  logic [3:0]                    sel_idx,
  input  logic                          cancel,
  input  logic                          restock,
  input  logic [NUM_ITEMS*CREDIT_W-1:0] price_flat,
  input  logic                          change_ack,
  output logic [CREDIT_W-1:0]           credit,
  output logic [1:0]                    state,
  output logic                          dispense_valid,
  output logic [3:0]                    dispense_idx,
  output logic                          change_valid,
  output logic [CREDIT_W-1:0]           change_amount,
  output logic                          coin_reject,
  output logic                          sel_deny,
  output logic [NUM_ITEMS-1:0]          sold_out
);
  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
  if (MAX_CREDIT >= (1 << CREDIT_W) || NUM_ITEMS < 2 || NUM_ITEMS > 16 || TIMEOUT_CYC < 2) begin : g_bad_params
    $fatal(1, "vending_core: illegal parameter set");
  end
  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d, change_amount_q, change_amount_d, sel_price;
  logic [STOCK_W-1:0]    stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]    stock_d [NUM_ITEMS];
  logic [STOCK_W-1:0]    sel_stock;
  logic [3:0]            dispense_idx_q, dispense_idx_d;
  logic [NUM_ITEMS-1:0]  sold_out_q, sold_out_d;
  logic                  dispense_valid_q, dispense_valid_d, change_valid_q, change_valid_d;
  logic                  coin_reject_q, coin_reject_d, sel_deny_q, sel_deny_d;
  logic                  sel_hit, dec, coin_fits, timed_out;
  logic [CREDIT_W:0]     coin_sum;
  // look up price and stock of the selected item; out-of-range indices never hit
  always_comb begin
    sel_hit   = 1'b0;
    sel_stock = '0;
    sel_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_idx == 4'(i)) begin
        sel_hit   = 1'b1;
        sel_stock = stock_q[i];
        sel_price = price_flat[i*CREDIT_W +: CREDIT_W];
      end
    end
  end
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_fits = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          activity;
  // idle counter in CREDIT; any accepted coin or sel/cancel restarts it
  always_comb begin
    activity  = cancel | sel_valid | (coin_valid & coin_fits);
    timed_out = state_q == CREDIT && !activity && to_cnt_q == TW'(TIMEOUT_CYC - 1);
    to_cnt_d  = (state_q != CREDIT || activity || timed_out) ? '0 : to_cnt_q + 1'b1;
  end
  // idle counter register
  always_ff @(posedge clk) to_cnt_q <= rst ? '0 : to_cnt_d;
`else
  assign timed_out = 1'b0;
`endif
  // next state, credit and response pulses
  always_comb begin
    state_d          = state_q;
    credit_d         = credit_q;
    dispense_valid_d = 1'b0;
    dispense_idx_d   = dispense_idx_q;
    coin_reject_d    = 1'b0;
    sel_deny_d       = 1'b0;
    dec              = 1'b0;
    case (state_q)
      IDLE: begin
        sel_deny_d = sel_valid;
        if (coin_valid) begin
          credit_d = coin_value;
          state_d  = CREDIT;
        end
      end
      CREDIT: begin
        if (cancel) begin
          state_d       = CHANGE;
          coin_reject_d = coin_valid;
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (!sel_hit || sel_stock == '0 || sel_price > credit_q) sel_deny_d = 1'b1;
          else begin
            credit_d         = credit_q - sel_price;
            dec              = 1'b1;
            dispense_valid_d = 1'b1;
            dispense_idx_d   = sel_idx;
            state_d          = VEND;
          end
        end else if (coin_valid) begin
          coin_reject_d = !coin_fits;
          credit_d      = coin_fits ? coin_sum[CREDIT_W-1:0] : credit_q;
        end
        if (timed_out) state_d = CHANGE;
      end
      VEND: begin
        coin_reject_d = coin_valid;
        sel_deny_d    = sel_valid;
        state_d       = credit_q == '0 ? IDLE : CHANGE;
      end
      default: begin
        coin_reject_d = coin_valid;
        sel_deny_d    = sel_valid;
        if (change_ack) begin
          credit_d = '0;
          state_d  = IDLE;
        end
      end
    endcase
    change_valid_d  = state_d == CHANGE;
    change_amount_d = state_d == CHANGE ? credit_d : '0;
  end
  // stock counters: restock overrides a same-cycle sale
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_d[i]    = restock ? STOCK_W'(STOCK_INIT) : (dec && sel_idx == 4'(i)) ? stock_q[i] - 1'b1 : stock_q[i];
      sold_out_d[i] = stock_d[i] == '0;
    end
  end
  // controller registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      credit_q         <= '0;
      dispense_valid_q <= 1'b0;
      dispense_idx_q   <= '0;
      change_valid_q   <= 1'b0;
      change_amount_q  <= '0;
      coin_reject_q    <= 1'b0;
      sel_deny_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      credit_q         <= credit_d;
      dispense_valid_q <= dispense_valid_d;
      dispense_idx_q   <= dispense_idx_d;
      change_valid_q   <= change_valid_d;
      change_amount_q  <= change_amount_d;
      coin_reject_q    <= coin_reject_d;
      sel_deny_q       <= sel_deny_d;
    end
  end
  // stock and sold-out registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= rst ? STOCK_W'(STOCK_INIT) : stock_d[i];
    sold_out_q <= rst ? {NUM_ITEMS{STOCK_INIT == 0}} : sold_out_d;
  end
  assign credit         = credit_q;
  assign state          = state_q;
  assign dispense_valid = dispense_valid_q;
  assign dispense_idx   = dispense_idx_q;
  assign change_valid   = change_valid_q;
  assign change_amount  = change_amount_q;
  assign coin_reject    = coin_reject_q;
  assign sel_deny       = sel_deny_q;
  assign sold_out       = sold_out_q;
endmodule

// File: doc/vending_core.md
# vending_core

Parametrised vending-machine controller: accumulates coin credit, validates item selections against per-item prices and stock, dispenses, and returns change through a handshake. Successor to the fixed 4-switch/3-button vending design; sits between the button/switch edge-detect front end and the LED/7-segment display driver, which render `credit` and the status outputs.

## Interface
Parameters:
- `NUM_ITEMS`, 4: number of selectable items (2–16).
- `CREDIT_W`, 8: width of credit, prices, coin values and change.
- `MAX_CREDIT`, 200: credit ceiling; must be < 2^CREDIT_W.
- `STOCK_W`, 4: width of each per-item stock counter.
- `STOCK_INIT`, 5: stock value loaded at reset and on `restock`.
- `TIMEOUT_CYC`, 1000: idle cycles before auto-refund (only with `VEND_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `coin_valid`  in  1  single-cycle pulse: coin inserted.
- `coin_value`  in  CREDIT_W  coin value, valid with `coin_valid`.
- `sel_valid`  in  1  single-cycle pulse: selection made.
- `sel_idx`  in  4  selected item index.
- `cancel`  in  1  single-cycle pulse: refund request.
- `restock`  in  1  reload all stock counters to STOCK_INIT.
- `price_flat`  in  NUM_ITEMS*CREDIT_W  item i price at bits [i*CREDIT_W +: CREDIT_W].
- `change_ack`  in  1  change dispenser accepted the amount.
- `credit`  out  CREDIT_W  current credit.
- `state`  out  2  0 IDLE, 1 CREDIT, 2 VEND, 3 CHANGE.
- `dispense_valid`  out  1  single-cycle pulse: dispense item.
- `dispense_idx`  out  4  item index, valid with `dispense_valid`.
- `change_valid`  out  1  change pending; held until ack.
- `change_amount`  out  CREDIT_W  change value, stable while `change_valid`.
- `coin_reject`  out  1  single-cycle pulse: coin returned, not credited.
- `sel_deny`  out  1  single-cycle pulse: selection refused.
- `sold_out`  out  NUM_ITEMS  bit i set when stock of item i is 0.

## Operation
- IDLE: credit 0. `coin_valid` → credit = coin_value, → CREDIT. `sel_valid` → `sel_deny`. `cancel` ignored.
- CREDIT: priority cancel > sel > coin.
  - `cancel` → CHANGE.
  - `sel_valid`: deny (stay) if sel_idx ≥ NUM_ITEMS, stock 0, or price > credit; price = 0 is legal. Otherwise credit −= price, stock[sel_idx] −= 1, `dispense_valid`/`dispense_idx` next cycle, → VEND.
  - `coin_valid`: if credit + coin_value > MAX_CREDIT (computed CREDIT_W+1 wide), `coin_reject`, credit unchanged; else add.
  - Coin coincident with sel or cancel → `coin_reject`.
- VEND: one cycle; dispense pulse asserted. Next: credit 0 → IDLE, else → CHANGE. Coins rejected, sel denied.
- CHANGE: `change_valid`=1, `change_amount`=credit. On `change_ack`: credit 0, → IDLE. Coins rejected, sel denied, cancel ignored.
- `restock` applies in any state; restock and a same-cycle decrement → STOCK_INIT wins.

## Timing
- All outputs registered; response pulses appear the cycle after the causing input.
- Reset: state IDLE, credit 0, all pulses 0, change_valid 0, change_amount 0, stocks STOCK_INIT, sold_out 0 (all ones if STOCK_INIT=0).
- Reset mid-VEND/CHANGE aborts silently: no dispense, no change, credit lost.
- `change_ack` without `change_valid` ignored; ack in same cycle `change_valid` first rises counts.
- Earliest sel→dispense: 1 cycle; CHANGE→IDLE: cycle after ack.

## Configuration
- `VEND_TIMEOUT_EN` defined: in CREDIT a counter clears on any accepted coin or sel/cancel input and increments otherwise; reaching TIMEOUT_CYC−1 → CHANGE (auto-refund). Counter cleared leaving CREDIT.
- Not defined: no counter; CREDIT held indefinitely; TIMEOUT_CYC unused.

## Test plan
- Reset, coins 50+50, price[2]=80, select 2 → dispense_idx 2 one cycle later, then change_valid with amount 20; ack → IDLE, credit 0.
- credit 180, coin 50 (MAX 200) → coin_reject, credit stays 180; coin 20 → credit 200.
- Select idx 7 (NUM_ITEMS=4), then item priced above credit → sel_deny each time, state CREDIT, credit unchanged.
- Buy item 1 five times with STOCK_INIT=5 → sold_out[1]=1, sixth select denied; restock → sold_out[1]=0.
- Same-cycle cancel+coin+sel at credit 30 → coin_reject, no dispense, change_amount 30.
- With VEND_TIMEOUT_EN, TIMEOUT_CYC=20: coin 10, idle 20 cycles → CHANGE, amount 10; without macro, state stays CREDIT after 100 cycles.
